// File: rtl/fifo_rd_ctrl.sv
// ============================================================================
// fifo_rd_ctrl
// ----------------------------------------------------------------------------
// Read-side controller of the asynchronous FIFO. It keeps the read pointer in
// binary and Gray form and compares it with the write pointer, which has
// already been synchronized into the read clock domain. It fetches words from
// a dual-port RAM with one cycle of read latency and presents them to the
// consumer through a registered valid/ready stage (first-word fall-through).
//
// This file also holds gray2bin. The controller uses it to convert the
// synchronized write pointer to binary for the fill-level output.
//
// Parameters
//   ADDR_WIDTH        RAM address width; pointers are ADDR_WIDTH+1 bits wide
//   DATA_WIDTH        data word width
//
// Ports
//   rclk_i            read-domain clock, the only clock of the block
//   rrst_n_i          synchronous active-low reset
//   wptr_gray_sync_i  write pointer (Gray), already synchronized into rclk_i
//   ren_o             RAM read enable (combinational)
//   raddr_o           RAM read address
//   rdata_i           RAM read data, valid the cycle after ren_o
//   rptr_gray_o       registered Gray read pointer for the write domain
//   rvalid_o          output word valid
//   rready_i          consumer accepts the word
//   rdata_o           registered output word
//   rempty_o          no word available to the consumer (= !rvalid_o)
//   rlevel_o          registered count of RAM entries not yet fetched
// ============================================================================

// ----------------------------------------------------------------------------
// gray2bin
//   i_gray  Gray-coded input of WIDTH bits
//   o_bin   binary equivalent
// ----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// ----------------------------------------------------------------------------
// fifo_rd_ctrl
// ----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk_i,
    input  logic                  rrst_n_i,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync_i,
    output logic                  ren_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [ADDR_WIDTH:0]   rptr_gray_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rempty_o,
    output logic [ADDR_WIDTH:0]   rlevel_o
);

    localparam int PW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [PW-1:0]         r_rbin;
    logic [PW-1:0]         r_rptrGray;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [PW-1:0]         r_rlevel;

    logic                  w_memEmpty;
    logic                  w_renRaw;
    logic                  w_ren;
    logic [PW-1:0]         w_rbinNext;
    logic [PW-1:0]         w_rgrayNext;
    logic [PW-1:0]         w_wbin;

    // Binary write pointer, used only for the fill level. The empty test
    // compares Gray codes directly so it never depends on this conversion.
    gray2bin #(
        .WIDTH (PW)
    ) u_gray2bin (
        .i_gray (wptr_gray_sync_i),
        .o_bin  (w_wbin)
    );

    // Equal Gray pointers, MSB included, mean every written word has been
    // fetched. The MSB separates the full case from the empty case.
    assign w_memEmpty = (r_rptrGray == wptr_gray_sync_i);

    // Next-state and read-enable logic. A read is issued from IDLE, or from
    // VALID when the held word is popped in the same cycle. This gives one
    // word every two cycles and keeps at most one word in flight.
    always_comb begin
        w_stateNext = r_state;
        w_renRaw    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_memEmpty) begin
                    w_renRaw    = 1'b1;
                    w_stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stateNext = ST_VALID;
            end
            ST_VALID: begin
                if (rready_i) begin
                    if (!w_memEmpty) begin
                        w_renRaw    = 1'b1;
                        w_stateNext = ST_WAIT;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // The read is suppressed while reset is asserted. The RAM is therefore
    // never read during reset, and the pointer below never advances then.
    assign w_ren = w_renRaw & rrst_n_i;

    // Post-increment pointer and its Gray code. This Gray value is registered
    // directly, so the pointer sent across domains changes one bit per step.
    always_comb begin
        w_rbinNext  = r_rbin;
        if (w_ren) begin
            w_rbinNext = r_rbin + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        w_rgrayNext = w_rbinNext ^ (w_rbinNext >> 1);
    end

    // State, pointers, output data and level. The level does not count the
    // word already fetched for this cycle's read, nor the word held at the
    // output. The subtraction wraps correctly at the pointer width.
    always_ff @(posedge rclk_i) begin
        if (!rrst_n_i) begin
            r_state    <= ST_IDLE;
            r_rbin     <= '0;
            r_rptrGray <= '0;
            r_rdata    <= '0;
            r_rlevel   <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_rbin     <= w_rbinNext;
            r_rptrGray <= w_rgrayNext;
            r_rlevel   <= w_wbin - w_rbinNext;
            if (r_state == ST_WAIT) begin
                r_rdata <= rdata_i;
            end
        end
    end

    assign ren_o       = w_ren;
    assign raddr_o     = r_rbin[ADDR_WIDTH-1:0];
    assign rptr_gray_o = r_rptrGray;
    assign rvalid_o    = (r_state == ST_VALID);
    assign rempty_o    = (r_state != ST_VALID);
    assign rdata_o     = r_rdata;
    assign rlevel_o    = r_rlevel;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ============================================================================
// tb_fifo_rd_ctrl
// ----------------------------------------------------------------------------
// Directed bench for fifo_rd_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8). The bench
// acts as the write side: it writes words into a behavioural RAM with one
// cycle of read latency and advances the Gray write pointer. Inputs change 1
// time unit after each rising edge. Outputs are sampled 1 time unit after
// that.
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstN;
    logic [AW:0]   wptrGray;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] ramOut;
    logic [AW:0]   rptrGray;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdataOut;
    logic          rempty;
    logic [AW:0]   rlevel;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   wbin;
    logic [DW-1:0] q [$];

    int errors = 0;
    int checks = 0;

    fifo_rd_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .rclk_i           (clk),
        .rrst_n_i         (rstN),
        .wptr_gray_sync_i (wptrGray),
        .ren_o            (ren),
        .raddr_o          (raddr),
        .rdata_i          (ramOut),
        .rptr_gray_o      (rptrGray),
        .rvalid_o         (rvalid),
        .rready_i         (rready),
        .rdata_o          (rdataOut),
        .rempty_o         (rempty),
        .rlevel_o         (rlevel)
    );

    // Clock with a 10-unit period.
    always #5 clk = ~clk;

    // RAM read port with one cycle of latency.
    always @(posedge clk) begin
        if (ren) ramOut <= mem[raddr];
    end

    function automatic logic [AW:0] toGray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance n clock cycles and stop 1 unit after the last rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write one word, as the write side would, and publish the new pointer.
    task automatic pushWord(input logic [DW-1:0] d);
        mem[wbin[AW-1:0]] = d;
        q.push_back(d);
        wbin     = wbin + 1'b1;
        wptrGray = toGray(wbin);
    endtask

    initial begin
        logic [AW:0] rdCount;
        logic [AW:0] lvlExp;
        logic [AW:0] prevGray;
        logic        popNow;
        logic        readNow;
        int          pushed;
        int          accepted;
        int          cyc;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ramOut = '0;
        rready = 1'b0;
        rstN   = 1'b0;

        // ---------------- Reset, with a non-empty write pointer -------------
        $display("[TB] reset");
        wbin     = 5'd2;
        wptrGray = 5'b00011;
        applyStimulus(3);
        checkOutput("rst_ren", ren, 1'b0);
        checkOutput("rst_rvalid", rvalid, 1'b0);
        checkOutput("rst_rempty", rempty, 1'b1);
        checkOutput("rst_rptr", rptrGray, 5'd0);
        checkOutput("rst_rlevel", rlevel, 5'd0);
        rstN = 1'b1;
        #1;
        checkOutput("rel_ren", ren, 1'b1);
        checkOutput("rel_raddr", raddr, 4'd0);
        // The write side is reset too before any edge, so the FIFO is empty.
        rstN     = 1'b0;
        wbin     = '0;
        wptrGray = '0;
        q.delete();
        #1;
        checkOutput("rst2_ren", ren, 1'b0);
        applyStimulus(2);
        rstN = 1'b1;
        applyStimulus(1);
        checkOutput("idle_ren", ren, 1'b0);

        // ---------------- Single word -----------------------------------------
        $display("[TB] single word");
        pushWord(8'hA5);
        #1;
        checkOutput("sw_ren_n", ren, 1'b1);
        checkOutput("sw_raddr_n", raddr, 4'd0);
        applyStimulus(1);
        checkOutput("sw_ren_n1", ren, 1'b0);
        checkOutput("sw_rvalid_n1", rvalid, 1'b0);
        rready = 1'b1;
        applyStimulus(1);
        checkOutput("sw_rvalid_n2", rvalid, 1'b1);
        checkOutput("sw_rdata_n2", rdataOut, 8'hA5);
        checkOutput("sw_rempty_n2", rempty, 1'b0);
        checkOutput("sw_rptr_n2", rptrGray, 5'd1);
        checkOutput("sw_rlevel_n2", rlevel, 5'd0);
        applyStimulus(1);
        checkOutput("sw_rvalid_n3", rvalid, 1'b0);
        checkOutput("sw_rempty_n3", rempty, 1'b1);
        q.delete();

        // ---------------- Backpressure ----------------------------------------
        $display("[TB] backpressure");
        rready = 1'b0;
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        #1;
        checkOutput("bp_ren", ren, 1'b1);
        checkOutput("bp_raddr", raddr, 4'd1);
        applyStimulus(1);
        checkOutput("bp_wait_ren", ren, 1'b0);
        checkOutput("bp_lvl_wait", rlevel, 5'd2);
        applyStimulus(1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", rvalid, 1'b1);
            checkOutput("bp_hold_data", rdataOut, 8'h11);
            checkOutput("bp_hold_ren", ren, 1'b0);
            checkOutput("bp_hold_lvl", rlevel, 5'd2);
            applyStimulus(1);
        end
        rready = 1'b1;
        #1;
        checkOutput("bp_pop1_ren", ren, 1'b1);
        checkOutput("bp_pop1_raddr", raddr, 4'd2);
        applyStimulus(1);
        checkOutput("bp_gap1_valid", rvalid, 1'b0);
        checkOutput("bp_gap1_lvl", rlevel, 5'd1);
        applyStimulus(1);
        checkOutput("bp_w2_valid", rvalid, 1'b1);
        checkOutput("bp_w2_data", rdataOut, 8'h22);
        checkOutput("bp_w2_ren", ren, 1'b1);
        checkOutput("bp_w2_raddr", raddr, 4'd3);
        applyStimulus(1);
        checkOutput("bp_gap2_valid", rvalid, 1'b0);
        checkOutput("bp_gap2_lvl", rlevel, 5'd0);
        applyStimulus(1);
        checkOutput("bp_w3_valid", rvalid, 1'b1);
        checkOutput("bp_w3_data", rdataOut, 8'h33);
        checkOutput("bp_w3_ren", ren, 1'b0);
        applyStimulus(1);
        checkOutput("bp_end_valid", rvalid, 1'b0);
        checkOutput("bp_end_rempty", rempty, 1'b1);
        checkOutput("bp_end_rptr", rptrGray, 5'd6);
        q.delete();

        // ---------------- Pop while the write pointer advances -----------------
        $display("[TB] simultaneous pop and write");
        rready = 1'b0;
        pushWord(8'h44);
        #1;
        checkOutput("sim_ren0", ren, 1'b1);
        checkOutput("sim_raddr0", raddr, 4'd4);
        applyStimulus(2);
        checkOutput("sim_valid44", rvalid, 1'b1);
        checkOutput("sim_data44", rdataOut, 8'h44);
        checkOutput("sim_ren_empty", ren, 1'b0);
        q.delete();
        rready = 1'b1;
        pushWord(8'h55);
        #1;
        checkOutput("sim_ren_pop", ren, 1'b1);
        checkOutput("sim_raddr_pop", raddr, 4'd5);
        applyStimulus(1);
        checkOutput("sim_gap_valid", rvalid, 1'b0);
        applyStimulus(1);
        checkOutput("sim_valid55", rvalid, 1'b1);
        checkOutput("sim_data55", rdataOut, 8'h55);
        checkOutput("sim_lvl55", rlevel, 5'd0);

        // ---------------- Streaming across the pointer wrap ----------------
        // 34 more words move the read pointer from 6 to 40, which is 8 modulo
        // 32. The RAM address wraps twice and the pointer MSB wraps once.
        $display("[TB] wrap-around stream");
        rdCount  = 5'd6;
        pushed   = 0;
        accepted = 0;
        cyc      = 0;
        while (accepted < 35 && cyc < 400) begin
            if (pushed < 34 && q.size() < 16) begin
                pushWord(8'(pushed * 7 + 3));
                pushed++;
            end
            #1;
            popNow  = rvalid;
            readNow = ren;
            if (popNow) checkOutput("wr_data", rdataOut, q[0]);
            if (readNow) checkOutput("wr_raddr", raddr, rdCount[AW-1:0]);
            lvlExp   = wbin - (rdCount + 5'(readNow));
            prevGray = rptrGray;
            applyStimulus(1);
            if (readNow) begin
                rdCount = rdCount + 1'b1;
                checkOutput("wr_gray_1bit", $countones(prevGray ^ rptrGray), 1);
            end
            checkOutput("wr_rptr", rptrGray, toGray(rdCount));
            checkOutput("wr_rlevel", rlevel, lvlExp);
            checkOutput("wr_rlevel_max", (rlevel <= 5'd16), 1'b1);
            if (popNow) begin
                void'(q.pop_front());
                accepted++;
            end
            cyc++;
        end
        checkOutput("wr_accepted", accepted, 35);
        checkOutput("wr_final_rdcount", rdCount, 5'd8);
        checkOutput("wr_final_rempty", rempty, 1'b1);
        checkOutput("wr_final_lvl", rlevel, 5'd0);

        // ---------------- Reset while a read is in flight -------------------
        $display("[TB] reset mid-operation");
        rready = 1'b0;
        q.delete();
        pushWord(8'h99);
        #1;
        checkOutput("mr_ren", ren, 1'b1);
        applyStimulus(1);
        checkOutput("mr_inwait_valid", rvalid, 1'b0);
        rstN     = 1'b0;
        wbin     = '0;
        wptrGray = '0;
        #1;
        checkOutput("mr_ren_gated", ren, 1'b0);
        applyStimulus(1);
        checkOutput("mr_rvalid", rvalid, 1'b0);
        checkOutput("mr_rempty", rempty, 1'b1);
        checkOutput("mr_rdata", rdataOut, 8'h00);
        checkOutput("mr_rptr", rptrGray, 5'd0);
        checkOutput("mr_rlevel", rlevel, 5'd0);
        rstN = 1'b1;
        applyStimulus(2);
        checkOutput("mr_post_valid", rvalid, 1'b0);
        checkOutput("mr_post_rdata", rdataOut, 8'h00);
        checkOutput("mr_post_ren", ren, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
